// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial sequencer between the unified RAM port, the instruction fetcher and the LSB.
// Optional macro MEMCTRL_FETCH_PRIO_EN: fetch wins arbitration over the LSB when both are pending.
`timescale 1ns/1ps
module mem_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_en,
  input  logic [31:0] if_pc,
  input  logic        if_drop,
  output logic        if_ok,
  output logic [31:0] if_inst,
  input  logic        lsb_en,
  input  logic        lsb_wr,
  input  logic [1:0]  lsb_size,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_ok,
  output logic [31:0] lsb_rdata,
  input  logic        rollback_flag
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t      r_state, w_state_next;
  logic        r_if_pend, r_ls_pend;
  logic [31:0] r_if_pc, r_ls_addr, r_ls_wdata;
  logic        r_ls_wr;
  logic [1:0]  r_ls_size;
  logic        r_cur_if, r_cur_io;
  logic [2:0]  r_n, r_cnt;
  logic [31:0] r_base, r_wdata, r_buf;
  logic [31:0] r_mem_a, r_if_inst, r_lsb_rdata;
  logic [7:0]  r_mem_dout;
  logic        r_mem_wr, r_if_ok, r_lsb_ok;

  logic        w_if_pend_eff, w_ls_pend_eff, w_pick_if, w_pick_ls, w_accept;
  logic [31:0] w_eff_pc, w_eff_addr, w_eff_wdata;
  logic        w_eff_wr;
  logic [1:0]  w_eff_size;
  logic [31:0] w_acc_base, w_acc_wdata;
  logic [2:0]  w_acc_n;
  logic        w_acc_wr, w_acc_io;
  logic        w_abort, w_rd_done, w_wr_done, w_wr_stall;
  logic [1:0]  w_byte_idx;
  logic [31:0] w_assembled;
  logic [7:0]  w_wr_byte;

  logic        w_cur_if_next, w_cur_io_next, w_mem_wr_next, w_if_ok_next, w_lsb_ok_next;
  logic [2:0]  w_n_next, w_cnt_next;
  logic [31:0] w_base_next, w_wdata_next, w_buf_next, w_mem_a_next, w_if_inst_next, w_lsb_rdata_next;
  logic [7:0]  w_mem_dout_next;

  function automatic logic [2:0] size_to_n(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // A request pulse counts as pending in its own cycle so IDLE can accept it at the latch edge.
  assign w_eff_pc      = if_en  ? if_pc     : r_if_pc;
  assign w_eff_wr      = lsb_en ? lsb_wr    : r_ls_wr;
  assign w_eff_size    = lsb_en ? lsb_size  : r_ls_size;
  assign w_eff_addr    = lsb_en ? lsb_addr  : r_ls_addr;
  assign w_eff_wdata   = lsb_en ? lsb_wdata : r_ls_wdata;
  assign w_if_pend_eff = if_en  | (r_if_pend & ~if_drop & ~rollback_flag);
  assign w_ls_pend_eff = lsb_en | (r_ls_pend & ~(rollback_flag & ~r_ls_wr));

`ifdef MEMCTRL_FETCH_PRIO_EN
  assign w_pick_if = w_if_pend_eff;
`else
  assign w_pick_if = w_if_pend_eff & ~w_ls_pend_eff;
`endif
  assign w_pick_ls = w_ls_pend_eff & ~w_pick_if;
  assign w_accept  = (r_state == S_IDLE) & (w_pick_if | w_pick_ls);

  assign w_acc_base  = w_pick_if ? w_eff_pc : w_eff_addr;
  assign w_acc_wdata = w_eff_wdata;
  assign w_acc_n     = w_pick_if ? 3'd4 : size_to_n(w_eff_size);
  assign w_acc_wr    = w_pick_ls & w_eff_wr;
  assign w_acc_io    = w_acc_base >= IO_BASE;

  assign w_abort     = (r_state == S_RD) & (rollback_flag | (r_cur_if & if_drop));
  assign w_rd_done   = r_cnt == (r_n + 3'd1);
  assign w_wr_done   = r_cnt == r_n;
  assign w_wr_stall  = r_cur_io & io_buffer_full;
  assign w_byte_idx  = 2'(r_cnt - 3'd2);
  assign w_assembled = r_buf | (32'(mem_din) << {w_byte_idx, 3'b000});
  assign w_wr_byte   = 8'(r_wdata >> {r_cnt[1:0], 3'b000});

  always_ff @(posedge clk_in) begin
    if (rst_in)
      r_state <= S_IDLE;
    else if (rdy_in)
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = w_acc_wr ? S_WR : S_RD;
      S_RD:    if (w_abort || w_rd_done) w_state_next = S_IDLE;
      S_WR:    if (w_wr_done) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cur_if_next    = r_cur_if;
    w_cur_io_next    = r_cur_io;
    w_n_next         = r_n;
    w_cnt_next       = r_cnt;
    w_base_next      = r_base;
    w_wdata_next     = r_wdata;
    w_buf_next       = r_buf;
    w_mem_a_next     = r_mem_a;
    w_mem_dout_next  = r_mem_dout;
    w_mem_wr_next    = r_mem_wr;
    w_if_ok_next     = 1'b0;
    w_lsb_ok_next    = 1'b0;
    w_if_inst_next   = r_if_inst;
    w_lsb_rdata_next = r_lsb_rdata;
    case (r_state)
      S_IDLE: begin
        w_mem_wr_next = 1'b0;
        w_mem_a_next  = 32'd0;
        if (w_accept) begin
          w_cur_if_next = w_pick_if;
          w_cur_io_next = w_acc_io;
          w_n_next      = w_acc_n;
          w_base_next   = w_acc_base;
          w_wdata_next  = w_acc_wdata;
          w_buf_next    = 32'd0;
          w_cnt_next    = 3'd1;
          if (!w_acc_wr) begin
            w_mem_a_next = w_acc_base;
          end else if (w_acc_io && io_buffer_full) begin
            w_cnt_next = 3'd0;
          end else begin
            w_mem_wr_next   = 1'b1;
            w_mem_a_next    = w_acc_base;
            w_mem_dout_next = w_acc_wdata[7:0];
          end
        end
      end
      S_RD: begin
        if (w_abort) begin
          w_mem_a_next = 32'd0;
          w_cnt_next   = 3'd0;
        end else begin
          if (r_cnt < r_n) w_mem_a_next = r_base + 32'(r_cnt);
          if (r_cnt >= 3'd2) w_buf_next = w_assembled;
          w_cnt_next = r_cnt + 3'd1;
          if (w_rd_done) begin
            w_cnt_next   = 3'd0;
            w_mem_a_next = 32'd0;
            if (r_cur_if) begin
              w_if_ok_next   = 1'b1;
              w_if_inst_next = w_assembled;
            end else begin
              w_lsb_ok_next    = 1'b1;
              w_lsb_rdata_next = w_assembled;
            end
          end
        end
      end
      S_WR: begin
        if (w_wr_done) begin
          w_mem_wr_next = 1'b0;
          w_mem_a_next  = 32'd0;
          w_lsb_ok_next = 1'b1;
          w_cnt_next    = 3'd0;
        end else if (w_wr_stall) begin
          w_mem_wr_next = 1'b0;
        end else begin
          w_mem_wr_next   = 1'b1;
          w_mem_a_next    = r_base + 32'(r_cnt);
          w_mem_dout_next = w_wr_byte;
          w_cnt_next      = r_cnt + 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_if_pend   <= 1'b0;
      r_ls_pend   <= 1'b0;
      r_if_pc     <= 32'd0;
      r_ls_wr     <= 1'b0;
      r_ls_size   <= 2'd0;
      r_ls_addr   <= 32'd0;
      r_ls_wdata  <= 32'd0;
      r_cur_if    <= 1'b0;
      r_cur_io    <= 1'b0;
      r_n         <= 3'd0;
      r_cnt       <= 3'd0;
      r_base      <= 32'd0;
      r_wdata     <= 32'd0;
      r_buf       <= 32'd0;
      r_mem_a     <= 32'd0;
      r_mem_dout  <= 8'd0;
      r_mem_wr    <= 1'b0;
      r_if_ok     <= 1'b0;
      r_lsb_ok    <= 1'b0;
      r_if_inst   <= 32'd0;
      r_lsb_rdata <= 32'd0;
    end else if (rdy_in) begin
      r_if_pend <= w_if_pend_eff & ~(w_accept & w_pick_if);
      r_ls_pend <= w_ls_pend_eff & ~(w_accept & w_pick_ls);
      if (if_en) r_if_pc <= if_pc;
      if (lsb_en) begin
        r_ls_wr    <= lsb_wr;
        r_ls_size  <= lsb_size;
        r_ls_addr  <= lsb_addr;
        r_ls_wdata <= lsb_wdata;
      end
      r_cur_if    <= w_cur_if_next;
      r_cur_io    <= w_cur_io_next;
      r_n         <= w_n_next;
      r_cnt       <= w_cnt_next;
      r_base      <= w_base_next;
      r_wdata     <= w_wdata_next;
      r_buf       <= w_buf_next;
      r_mem_a     <= w_mem_a_next;
      r_mem_dout  <= w_mem_dout_next;
      r_mem_wr    <= w_mem_wr_next;
      r_if_ok     <= w_if_ok_next;
      r_lsb_ok    <= w_lsb_ok_next;
      r_if_inst   <= w_if_inst_next;
      r_lsb_rdata <= w_lsb_rdata_next;
    end
  end

  assign mem_a     = r_mem_a;
  assign mem_dout  = r_mem_dout;
  assign mem_wr    = r_mem_wr & rdy_in;
  assign if_ok     = r_if_ok;
  assign if_inst   = r_if_inst;
  assign lsb_ok    = r_lsb_ok;
  assign lsb_rdata = r_lsb_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, table of single requests, then directed multi-cycle sequences.
`timescale 1ns/1ps
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, mem_wr, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        if_en, if_drop, if_ok, lsb_en, lsb_wr, lsb_ok, rollback_flag;
  logic [31:0] if_pc, if_inst, lsb_addr, lsb_wdata, lsb_rdata;
  logic [1:0]  lsb_size;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_en(if_en), .if_pc(if_pc), .if_drop(if_drop), .if_ok(if_ok), .if_inst(if_inst),
    .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_ok(lsb_ok), .lsb_rdata(lsb_rdata),
    .rollback_flag(rollback_flag)
  );

  // RAM model: one-cycle read latency, frozen together with the rest of the system when rdy_in=0.
  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    if (rst_in) begin
      ram[16'h0100] <= 8'h13; ram[16'h0101] <= 8'h05; ram[16'h0102] <= 8'h00; ram[16'h0103] <= 8'h00;
      ram[16'h0104] <= 8'h93; ram[16'h0105] <= 8'h00; ram[16'h0106] <= 8'h10; ram[16'h0107] <= 8'h00;
      ram[16'h0200] <= 8'hFF;
      ram[16'h0300] <= 8'h11; ram[16'h0301] <= 8'h22; ram[16'h0302] <= 8'h33; ram[16'h0303] <= 8'h44;
      ram[16'hFFFF] <= 8'hAB; ram[16'h0000] <= 8'hCD;
    end else if (rdy_in) begin
      mem_din <= ram[mem_a[15:0]];
      if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    end
  end

  typedef struct {
    logic        f;
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic f, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    if (f) begin
      if_en = 1'b1; if_pc = a;
    end else begin
      lsb_en = 1'b1; lsb_wr = wr; lsb_size = sz; lsb_addr = a; lsb_wdata = wd;
    end
  endtask

  // Issues one request, passes the accept edge, and counts edges until the ok pulse (99 = none).
  task automatic run_req(input logic f, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] data);
    issue(f, wr, sz, a, wd);
    tick();
    if_en = 1'b0; lsb_en = 1'b0;
    lat = 99;
    data = 32'hxxxx_xxxx;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (f ? if_ok : lsb_ok) begin
        lat = k;
        data = f ? if_inst : lsb_rdata;
        break;
      end
    end
  endtask

  initial begin
    int lat, fk, lk, wrs;
    logic [31:0] data, fdata, ldata;
    logic seen;

    tbl[0]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0100, 32'h0, 32'h0000_0513, 5};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0104, 32'h0, 32'h0010_0093, 5};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0200, 32'h0, 32'h0000_00FF, 2};
    tbl[3]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0302, 32'h0, 32'h0000_4433, 3};
    tbl[4]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0300, 32'h0, 32'h4433_2211, 5};
    tbl[5]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0300, 32'h0, 32'h4433_2211, 5};
    tbl[6]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0303, 32'h0, 32'h0000_0044, 2};
    tbl[7]  = '{1'b0, 1'b1, 2'd2, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 4};
    tbl[8]  = '{1'b0, 1'b0, 2'd2, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 5};
    tbl[9]  = '{1'b0, 1'b1, 2'd2, 32'h0000_2000, 32'h0102_0304, 32'h0, 4};
    tbl[10] = '{1'b0, 1'b1, 2'd1, 32'h0000_2000, 32'h1234_ABCD, 32'h0, 2};
    tbl[11] = '{1'b0, 1'b1, 2'd0, 32'h0000_2003, 32'h0000_0077, 32'h0, 1};
    tbl[12] = '{1'b0, 1'b0, 2'd2, 32'h0000_2000, 32'h0, 32'h7702_ABCD, 5};
    tbl[13] = '{1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0, 32'h0000_CDAB, 3};
    tbl[14] = '{1'b0, 1'b0, 2'd0, 32'h0000_1001, 32'h0, 32'h0000_00BE, 2};

    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
    if_en = 1'b0; if_pc = '0; if_drop = 1'b0;
    lsb_en = 1'b0; lsb_wr = 1'b0; lsb_size = '0; lsb_addr = '0; lsb_wdata = '0;
    rollback_flag = 1'b0;
    repeat (3) tick();
    rst_in = 1'b0;
    tick();
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
    check("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
    check("rst_oks", {30'h0, if_ok, lsb_ok}, 32'h0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_lsb_rdata", lsb_rdata, 32'h0);

    foreach (tbl[i]) begin
      run_req(tbl[i].f, tbl[i].wr, tbl[i].sz, tbl[i].addr, tbl[i].wd, lat, data);
      $display("vec %0d f=%0b wr=%0b sz=%0d addr=%h lat=%0d data=%h", i, tbl[i].f, tbl[i].wr,
               tbl[i].sz, tbl[i].addr, lat, data);
      check($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
      if (!tbl[i].wr) check($sformatf("vec%0d_data", i), data, tbl[i].exp);
      tick();
      check($sformatf("vec%0d_okpulse", i), {30'h0, if_ok, lsb_ok}, 32'h0);
      check($sformatf("vec%0d_idle_a", i), {mem_a[31:1], mem_wr}, 32'h0);
    end

    // Fetch address walk and exact latency.
    issue(1'b1, 1'b0, 2'd0, 32'h100, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if_en = 1'b0;
      check($sformatf("fetch_a%0d", k), mem_a, 32'h100 + k);
    end
    tick();
    check("fetch_early_ok", {31'h0, if_ok}, 32'h0);
    tick();
    check("fetch_ok", {31'h0, if_ok}, 32'h1);
    check("fetch_inst", if_inst, 32'h0000_0513);
    $display("seq fetch_walk inst=%h", if_inst);
    tick();

    // Simultaneous fetch and byte load: arbitration order.
    issue(1'b1, 1'b0, 2'd0, 32'h100, 32'h0);
    issue(1'b0, 1'b0, 2'd0, 32'h200, 32'h0);
    tick();
    if_en = 1'b0; lsb_en = 1'b0;
    fk = 99; lk = 99; fdata = '0; ldata = '0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (if_ok)  begin fk = k; fdata = if_inst; end
      if (lsb_ok) begin lk = k; ldata = lsb_rdata; end
    end
`ifdef MEMCTRL_FETCH_PRIO_EN
    check("arb_fetch_edge", fk, 5);
    check("arb_load_edge", lk, 8);
`else
    check("arb_load_edge", lk, 2);
    check("arb_fetch_edge", fk, 8);
`endif
    check("arb_inst", fdata, 32'h0000_0513);
    check("arb_rdata", ldata, 32'h0000_00FF);
    $display("seq arbitration fetch_edge=%0d load_edge=%0d", fk, lk);

    // Word store byte sequence.
    issue(1'b0, 1'b1, 2'd2, 32'h1000, 32'hDEAD_BEEF);
    for (int k = 0; k < 4; k++) begin
      tick();
      lsb_en = 1'b0;
      check($sformatf("st_wr%0d", k), {31'h0, mem_wr}, 32'h1);
      check($sformatf("st_a%0d", k), mem_a, 32'h1000 + k);
      data = 32'hDEAD_BEEF >> (8 * k);
      check($sformatf("st_d%0d", k), {24'h0, mem_dout}, {24'h0, data[7:0]});
    end
    tick();
    check("st_end_wr", {31'h0, mem_wr}, 32'h0);
    check("st_ok", {31'h0, lsb_ok}, 32'h1);
    $display("seq store_word done");
    tick();

    // Fetch dropped mid-flight, then a fresh fetch.
    issue(1'b1, 1'b0, 2'd0, 32'h100, 32'h0);
    tick();
    if_en = 1'b0;
    tick();
    if_drop = 1'b1;
    tick();
    if_drop = 1'b0;
    check("drop_mem_a", mem_a, 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (if_ok) seen = 1'b1;
    end
    check("drop_no_ok", {31'h0, seen}, 32'h0);
    run_req(1'b1, 1'b0, 2'd0, 32'h104, 32'h0, lat, data);
    check("drop_refetch_lat", lat, 5);
    check("drop_refetch_inst", data, 32'h0010_0093);
    $display("seq drop refetch lat=%0d inst=%h", lat, data);
    tick();

    // IO store held off by io_buffer_full for three cycles.
    io_buffer_full = 1'b1;
    issue(1'b0, 1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041);
    for (int k = 0; k < 3; k++) begin
      tick();
      lsb_en = 1'b0;
      check($sformatf("io_stall%0d", k), {31'h0, mem_wr}, 32'h0);
    end
    io_buffer_full = 1'b0;
    tick();
    check("io_wr", {31'h0, mem_wr}, 32'h1);
    check("io_dout", {24'h0, mem_dout}, 32'h41);
    check("io_a", mem_a, 32'h0003_0000);
    tick();
    check("io_ok", {31'h0, lsb_ok}, 32'h1);
    $display("seq io_store done");
    tick();

    // Rollback aborts a half load but not a word store.
    issue(1'b0, 1'b0, 2'd1, 32'h300, 32'h0);
    tick();
    lsb_en = 1'b0;
    rollback_flag = 1'b1;
    tick();
    rollback_flag = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (lsb_ok) seen = 1'b1;
    end
    check("rb_load_no_ok", {31'h0, seen}, 32'h0);
    issue(1'b0, 1'b1, 2'd2, 32'h3000, 32'hCAFE_F00D);
    tick();
    lsb_en = 1'b0;
    wrs = int'(mem_wr);
    rollback_flag = 1'b1;
    lk = 99;
    for (int k = 1; k <= 8; k++) begin
      tick();
      rollback_flag = 1'b0;
      wrs += int'(mem_wr);
      if (lsb_ok && lk == 99) lk = k;
    end
    check("rb_store_wrs", wrs, 4);
    check("rb_store_ok", lk, 4);
    run_req(1'b0, 1'b0, 2'd2, 32'h3000, 32'h0, lat, data);
    check("rb_store_data", data, 32'hCAFE_F00D);
    $display("seq rollback store_wrs=%0d readback=%h", wrs, data);
    tick();

    // rdy_in low freezes an in-flight fetch.
    issue(1'b1, 1'b0, 2'd0, 32'h100, 32'h0);
    tick();
    if_en = 1'b0;
    tick();
    check("frz_a1", mem_a, 32'h101);
    rdy_in = 1'b0;
    tick();
    check("frz_a2", mem_a, 32'h101);
    tick();
    check("frz_a3", mem_a, 32'h101);
    rdy_in = 1'b1;
    fk = 99; fdata = '0;
    for (int k = 4; k <= 15; k++) begin
      tick();
      if (if_ok && fk == 99) begin fk = k; fdata = if_inst; end
    end
    check("frz_fetch_edge", fk, 7);
    check("frz_fetch_inst", fdata, 32'h0000_0513);
    $display("seq freeze fetch_edge=%0d inst=%h", fk, fdata);

    // rdy_in low gates mem_wr immediately.
    issue(1'b0, 1'b1, 2'd0, 32'h5000, 32'h0000_005A);
    tick();
    lsb_en = 1'b0;
    check("frz_st_wr", {31'h0, mem_wr}, 32'h1);
    rdy_in = 1'b0;
    #1;
    check("frz_st_gated", {31'h0, mem_wr}, 32'h0);
    tick();
    check("frz_st_no_ok", {31'h0, lsb_ok}, 32'h0);
    rdy_in = 1'b1;
    #1;
    check("frz_st_resume", {31'h0, mem_wr}, 32'h1);
    tick();
    check("frz_st_ok", {31'h0, lsb_ok}, 32'h1);
    tick();
    run_req(1'b0, 1'b0, 2'd0, 32'h5000, 32'h0, lat, data);
    check("frz_st_data", data, 32'h0000_005A);
    $display("seq freeze store readback=%h", data);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
